bc_link_endpoint: RTL and testbench
===================================

# bc_link_endpoint

Avoidance-side endpoint of the breadcrumb serial link. It deserializes 16-bit breadcrumbs arriving MSB-first from the breadcrumb buffer's serializer and queues them in a small local FIFO for the avoidance logic. It also serializes 16-bit avoidance command words back toward the buffer's deserializer. It issues the read request that paces the buffer's FIFO reads.

## Interface
Parameters:
- WIDTH, 16, breadcrumb/command word width
- DEPTH, 4, local RX FIFO depth; must be a power of 2 and ≥2

Ports:
- clk  in  1  single clock; all serial bits are one clk cycle each
- rst  in  1  reset, asynchronous, active-low
- bc_req  out  1  request to buffer; high when (fifo count + rx_busy) < DEPTH
- ser_in  in  1  serial breadcrumb data, MSB first
- ser_in_start  in  1  marks the cycle carrying bit WIDTH-1
- bc_valid  out  1  local FIFO non-empty
- bc_data  out  WIDTH  FIFO head word; valid only while bc_valid
- bc_ready  in  1  consumer pops head when bc_valid & bc_ready
- cmd_valid  in  1  command word offered
- cmd_data  in  WIDTH  command word
- cmd_ready  out  1  TX idle; command accepted on cmd_valid & cmd_ready
- ser_out  out  1  serial command data, MSB first
- ser_out_start  out  1  high on the cycle ser_out carries bit WIDTH-1
- ser_out_done  out  1  one-cycle pulse after the last bit
- rx_overflow  out  1  sticky; set when a completed word found the FIFO full

## Operation
- Reset values:
  - bc_req=1
  - bc_valid=0, bc_data=0
  - cmd_ready=1
  - ser_out=0, ser_out_start=0, ser_out_done=0
  - rx_overflow=0
  - FIFO pointers and count = 0; RX and TX FSMs in IDLE
- RX FSM: IDLE → SHIFT on ser_in_start.
  - ser_in is sampled every cycle in SHIFT; bit counter counts WIDTH-1 down to 0.
  - After the bit-0 sample: push to FIFO and return to IDLE.
  - ser_in_start while in SHIFT is ignored; framing is by count only.
- RX push rule: push succeeds if count<DEPTH, or if a pop occurs the same cycle. Otherwise the word is dropped and rx_overflow is set.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop: count is unchanged, both pointers advance.
  - Pop when empty is ignored.
- TX FSM: IDLE → SHIFT on accept, latching cmd_data.
  - SHIFT drives bits WIDTH-1..0 on consecutive cycles, then goes to DONE.
  - DONE lasts one cycle (ser_out_done=1) and then returns to IDLE.
  - cmd_ready=1 only in IDLE.
  - ser_out=0 outside SHIFT.
- RX and TX paths are fully independent and may run concurrently.
- Reset asserted mid-frame aborts both FSMs immediately. A partial word is discarded and FIFO contents are lost.

## Timing
- RX: ser_in_start at cycle t means bit WIDTH-1 is sampled at t and bit 0 at t+WIDTH-1. The word is written at the end of t+WIDTH-1; bc_valid/bc_data are visible at t+WIDTH.
- bc_req is combinational from registered count and rx_busy. It drops the cycle after a start that fills the last free slot.
- Pop at cycle p: the next head appears at p+1.
- TX: accept at cycle a; ser_out_start=1 and bit WIDTH-1 at a+1; bit 0 at a+WIDTH; ser_out_done at a+WIDTH+1; cmd_ready high again at a+WIDTH+2. Frame period is WIDTH+2 cycles back-to-back.
- All outputs are registered except bc_req, cmd_ready (FSM-state decode), bc_valid and bc_data (FIFO read mux).

## Structure
- Shared package bc_link_pkg:
  - BC_WIDTH=16
  - rx_state_t {RX_IDLE, RX_SHIFT}
  - tx_state_t {TX_IDLE, TX_SHIFT, TX_DONE}
- Sub-module bc_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) holds the local queue.
- RX and TX shift logic live in bc_link_endpoint.

## Test plan
- Reset, then ser_in_start with word 0xA5C3 serialized MSB-first → bc_valid rises 16 cycles after start, bc_data=0xA5C3, rx_overflow=0.
- Four back-to-back frames 0x0001, 0x0002, 0x0003, 0x0004 with bc_ready=0 → bc_req low after the 4th start; bc_data pops in order 1,2,3,4; a 5th frame 0xFFFF completing with bc_ready=0 sets rx_overflow and 0xFFFF never appears.
- FIFO full, pop on the same cycle a 5th frame 0x1234 completes → no overflow; 0x1234 is read after 2,3,4; pointer wrap verified.
- cmd_data=0x8001 accepted at cycle a → ser_out 1 at a+1, 0 for a+2..a+15, 1 at a+16; ser_out_done at a+17; cmd_ready at a+18.
- Concurrent RX 0x5A5A and TX 0x3C3C → both complete with correct data and unchanged latency.
- rst asserted at bit 7 of an RX frame and mid-TX → all outputs at reset values immediately; no word is pushed; a new frame 0x00FF after release is received correctly.

Source files
------------

// File: rtl/bc_link_pkg.sv
// Shared definitions for the breadcrumb serial link.
//   BC_WIDTH   : breadcrumb / command word width
//   rx_state_t : receive deserializer states
//   tx_state_t : transmit serializer states
package bc_link_pkg;
  localparam int BC_WIDTH = 16;

  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/bc_sync_fifo.sv
// Small synchronous FIFO holding received breadcrumbs.
//   clk, rst  : clock, asynchronous active-low reset
//   push      : write push_data (taken if not full, or if a pop happens too)
//   pop       : drop the head word (ignored while empty)
//   head      : current head word, forced to 0 while empty
//   full/empty/count : occupancy status, count is log2(DEPTH)+1 bits
module bc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/bc_link_endpoint.sv
// Avoidance-side endpoint of the breadcrumb serial link.
// RX deserializes MSB-first breadcrumbs into a local FIFO; TX serializes
// command words MSB-first back toward the buffer.
//   clk, rst                 : clock, asynchronous active-low reset
//   bc_req                   : room for one more word (count + rx_busy < DEPTH)
//   ser_in, ser_in_start     : serial breadcrumb bits, start marks bit WIDTH-1
//   bc_valid/bc_data/bc_ready: FIFO head handshake
//   cmd_valid/cmd_data/cmd_ready : command word handshake
//   ser_out, ser_out_start, ser_out_done : serial command output
//   rx_overflow              : sticky, a completed word was dropped
//   rx_state_dbg, tx_state_dbg : current FSM states
// Handshakes: a transfer happens on every cycle where valid and ready are both
// high at the rising clock edge; valid does not depend on ready.
module bc_link_endpoint
  import bc_link_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bc_req,
  input  logic             ser_in,
  input  logic             ser_in_start,
  output logic             bc_valid,
  output logic [WIDTH-1:0] bc_data,
  input  logic             bc_ready,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             ser_out,
  output logic             ser_out_start,
  output logic             ser_out_done,
  output logic             rx_overflow,
  output logic             rx_state_dbg,
  output logic [1:0]       tx_state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  // ---------------- RX ----------------
  rx_state_t        rx_st;
  logic [CW-1:0]    rx_cnt;      // index of the bit sampled next
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_word;
  logic             rx_last;
  logic             rx_busy;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  assign rx_busy = (rx_st == RX_SHIFT);
  assign rx_last = rx_busy && (rx_cnt == '0);
  // The final bit is merged combinationally so the word is written in the
  // same cycle bit 0 is on the line.
  assign rx_word = {rx_shift, ser_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st       <= RX_IDLE;
      rx_cnt      <= '0;
      rx_shift    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          if (ser_in_start) begin
            rx_shift <= {{(WIDTH-2){1'b0}}, ser_in};
            rx_cnt   <= CW'(WIDTH-2);
            rx_st    <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          // ser_in_start is not looked at here: framing is by count only.
          rx_shift <= rx_word[WIDTH-2:0];
          if (rx_cnt == '0) rx_st  <= RX_IDLE;
          else              rx_cnt <= rx_cnt - 1'b1;
        end
        default: rx_st <= RX_IDLE;
      endcase
      // Full implies non-empty, so bc_ready alone means a real pop.
      if (rx_last && fifo_full && !bc_ready) rx_overflow <= 1'b1;
    end
  end

  bc_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_last),
    .push_data (rx_word),
    .pop       (bc_ready),
    .head      (bc_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bc_valid = ~fifo_empty;
  // A frame in flight already owns a slot, so it is counted against DEPTH.
  assign bc_req = (({1'b0, fifo_count} + (AW+2)'(rx_busy)) < (AW+2)'(DEPTH));

  // ---------------- TX ----------------
  tx_state_t        tx_st;
  logic [CW-1:0]    tx_cnt;      // bit index currently on ser_out
  logic [WIDTH-1:0] tx_shift;    // remaining bits, next one at the MSB

  assign cmd_ready = (tx_st == TX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st         <= TX_IDLE;
      tx_cnt        <= '0;
      tx_shift      <= '0;
      ser_out       <= 1'b0;
      ser_out_start <= 1'b0;
      ser_out_done  <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          if (cmd_valid) begin
            ser_out       <= cmd_data[WIDTH-1];
            ser_out_start <= 1'b1;
            tx_shift      <= {cmd_data[WIDTH-2:0], 1'b0};
            tx_cnt        <= CW'(WIDTH-1);
            tx_st         <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          ser_out_start <= 1'b0;
          if (tx_cnt == '0) begin
            ser_out      <= 1'b0;
            ser_out_done <= 1'b1;
            tx_st        <= TX_DONE;
          end else begin
            ser_out  <= tx_shift[WIDTH-1];
            tx_shift <= tx_shift << 1;
            tx_cnt   <= tx_cnt - 1'b1;
          end
        end
        TX_DONE: begin
          ser_out_done <= 1'b0;
          tx_st        <= TX_IDLE;
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  assign rx_state_dbg = rx_st;
  assign tx_state_dbg = tx_st;
endmodule

// File: tb/tb_bc_link_endpoint.sv
// Bench for bc_link_endpoint: directed frames plus a short random section.
// Inputs change 1 ns after the rising edge; monitors sample on the falling edge.
module tb_bc_link_endpoint;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             bc_req;
  logic             ser_in;
  logic             ser_in_start;
  logic             bc_valid;
  logic [WIDTH-1:0] bc_data;
  logic             bc_ready;
  logic             cmd_valid;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic             ser_out;
  logic             ser_out_start;
  logic             ser_out_done;
  logic             rx_overflow;
  logic             rx_state_dbg;
  logic [1:0]       tx_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] rx_exp_q[$];
  logic [WIDTH-1:0] tx_exp_q[$];

  logic [WIDTH-1:0] tx_word;
  int               tx_bits;

  bc_link_endpoint #(.WIDTH(WIDTH), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bc_req        (bc_req),
    .ser_in        (ser_in),
    .ser_in_start  (ser_in_start),
    .bc_valid      (bc_valid),
    .bc_data       (bc_data),
    .bc_ready      (bc_ready),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .ser_out       (ser_out),
    .ser_out_start (ser_out_start),
    .ser_out_done  (ser_out_done),
    .rx_overflow   (rx_overflow),
    .rx_state_dbg  (rx_state_dbg),
    .tx_state_dbg  (tx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RX scoreboard: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && bc_valid && bc_ready) begin
      check("rx_q_nonempty", 32'(rx_exp_q.size() > 0), 32'd1);
      if (rx_exp_q.size() > 0) check("rx_word", 32'(bc_data), 32'(rx_exp_q.pop_front()));
    end
  end

  // TX scoreboard: rebuild the serial word and compare on ser_out_done.
  always @(negedge clk) begin
    if (!rst) begin
      tx_bits = 0;
      tx_word = '0;
    end else begin
      if (ser_out_start) begin
        tx_word = {{(WIDTH-1){1'b0}}, ser_out};
        tx_bits = 1;
      end else if (tx_bits > 0 && tx_bits < WIDTH) begin
        tx_word = {tx_word[WIDTH-2:0], ser_out};
        tx_bits++;
      end
      if (ser_out_done) begin
        check("tx_bit_count", 32'(tx_bits), 32'(WIDTH));
        check("tx_q_nonempty", 32'(tx_exp_q.size() > 0), 32'd1);
        if (tx_exp_q.size() > 0) check("tx_word", 32'(tx_word), 32'(tx_exp_q.pop_front()));
        tx_bits = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bc_req"},        32'(bc_req),        32'd1);
    check({tag, "_bc_valid"},      32'(bc_valid),      32'd0);
    check({tag, "_bc_data"},       32'(bc_data),       32'd0);
    check({tag, "_cmd_ready"},     32'(cmd_ready),     32'd1);
    check({tag, "_ser_out"},       32'(ser_out),       32'd0);
    check({tag, "_ser_out_start"}, 32'(ser_out_start), 32'd0);
    check({tag, "_ser_out_done"},  32'(ser_out_done),  32'd0);
    check({tag, "_rx_overflow"},   32'(rx_overflow),   32'd0);
    check({tag, "_rx_state"},      32'(rx_state_dbg),  32'd0);
    check({tag, "_tx_state"},      32'(tx_state_dbg),  32'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    ser_in       = 1'b0;
    ser_in_start = 1'b0;
    bc_ready     = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    step(2);
    check_reset_values("rst");
    rx_exp_q.delete();
    tx_exp_q.delete();
    rst = 1'b1;
    step(1);
  endtask

  // Drive bits hi..lo of w, one per cycle; start accompanies bit WIDTH-1.
  // When bit 0 is sent and keep is set, the word is expected at the output.
  task automatic rx_bits(input logic [WIDTH-1:0] w, input int hi, input int lo, input bit keep);
    for (int i = hi; i >= lo; i--) begin
      ser_in       = w[i];
      ser_in_start = (i == WIDTH-1);
      step(1);
    end
    ser_in       = 1'b0;
    ser_in_start = 1'b0;
    if (lo == 0 && keep) rx_exp_q.push_back(w);
  endtask

  // Offer w and return in the cycle after acceptance.
  task automatic tx_accept(input logic [WIDTH-1:0] w);
    int k;
    cmd_data  = w;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step(1);
      k++;
    end
    check("tx_accept_ready", 32'(cmd_ready), 32'd1);
    tx_exp_q.push_back(w);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic tx_run(input logic [WIDTH-1:0] w);
    int k;
    tx_accept(w);
    k = 1;
    while (!ser_out_done && k < 40) begin
      step(1);
      k++;
    end
    check("tx_done_latency", 32'(k), 32'(WIDTH+1));
    step(1);
    check("tx_ready_again", 32'(cmd_ready), 32'd1);
  endtask

  task automatic drain();
    int k;
    bc_ready = 1'b1;
    k = 0;
    while (bc_valid && k < 20) begin
      step(1);
      k++;
    end
    bc_ready = 1'b0;
    check("drain_empty", 32'(bc_valid), 32'd0);
    check("drain_q_empty", 32'(rx_exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    ser_in       = 1'b0;
    ser_in_start = 1'b0;
    bc_ready     = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    tx_bits      = 0;
    tx_word      = '0;

    // 1: single frame, latency and data
    do_reset();
    rx_bits(16'hA5C3, 15, 1, 1'b0);
    check("t1_not_valid_yet", 32'(bc_valid), 32'd0);
    rx_bits(16'hA5C3, 0, 0, 1'b1);
    check("t1_valid", 32'(bc_valid), 32'd1);
    check("t1_data", 32'(bc_data), 32'hA5C3);
    check("t1_overflow", 32'(rx_overflow), 32'd0);
    drain();

    // 2: fill FIFO, bc_req drop, overflow on a 5th frame
    do_reset();
    rx_bits(16'h0001, 15, 0, 1'b1);
    rx_bits(16'h0002, 15, 0, 1'b1);
    rx_bits(16'h0003, 15, 0, 1'b1);
    check("t2_req_before_4th", 32'(bc_req), 32'd1);
    rx_bits(16'h0004, 15, 15, 1'b0);
    check("t2_req_drop", 32'(bc_req), 32'd0);
    rx_bits(16'h0004, 14, 0, 1'b1);
    check("t2_req_full", 32'(bc_req), 32'd0);
    check("t2_no_overflow_yet", 32'(rx_overflow), 32'd0);
    rx_bits(16'hFFFF, 15, 0, 1'b0);
    check("t2_overflow", 32'(rx_overflow), 32'd1);
    check("t2_head_kept", 32'(bc_data), 32'h0001);
    drain();
    check("t2_req_back", 32'(bc_req), 32'd1);
    check("t2_overflow_sticky", 32'(rx_overflow), 32'd1);

    // 3: full FIFO, pop in the cycle the 5th word completes, pointer wrap
    do_reset();
    rx_bits(16'h0001, 15, 0, 1'b1);
    rx_bits(16'h0002, 15, 0, 1'b1);
    rx_bits(16'h0003, 15, 0, 1'b1);
    rx_bits(16'h0004, 15, 0, 1'b1);
    rx_bits(16'h1234, 15, 1, 1'b0);
    bc_ready = 1'b1;
    rx_bits(16'h1234, 0, 0, 1'b1);
    bc_ready = 1'b0;
    check("t3_no_overflow", 32'(rx_overflow), 32'd0);
    check("t3_head_after_pop", 32'(bc_data), 32'h0002);
    check("t3_still_full", 32'(bc_req), 32'd0);
    drain();

    // 4: TX frame timing for 0x8001
    do_reset();
    tx_accept(16'h8001);
    for (int k = 1; k <= WIDTH + 2; k++) begin
      check($sformatf("t4_ser_out_a%0d", k), 32'(ser_out), 32'((k == 1) || (k == WIDTH)));
      check($sformatf("t4_start_a%0d", k), 32'(ser_out_start), 32'(k == 1));
      check($sformatf("t4_done_a%0d", k), 32'(ser_out_done), 32'(k == WIDTH + 1));
      check($sformatf("t4_ready_a%0d", k), 32'(cmd_ready), 32'(k == WIDTH + 2));
      step(1);
    end

    // 5: concurrent RX and TX
    do_reset();
    fork
      begin
        rx_bits(16'h5A5A, 15, 1, 1'b0);
        check("t5_rx_not_yet", 32'(bc_valid), 32'd0);
        rx_bits(16'h5A5A, 0, 0, 1'b1);
        check("t5_rx_valid", 32'(bc_valid), 32'd1);
        check("t5_rx_data", 32'(bc_data), 32'h5A5A);
      end
      tx_run(16'h3C3C);
    join
    drain();
    check("t5_tx_q_empty", 32'(tx_exp_q.size()), 32'd0);

    // 6: reset in the middle of RX and TX frames, with a word already queued
    do_reset();
    rx_bits(16'h7777, 15, 0, 1'b1);
    fork
      tx_accept(16'hFFFF);
      rx_bits(16'h0F0F, 15, 8, 1'b0);
    join
    check("t6_tx_busy", 32'(ser_out), 32'd1);
    ser_in = 1'b1;
    rst    = 1'b0;
    #1;
    check_reset_values("t6_async");
    rx_exp_q.delete();
    tx_exp_q.delete();
    ser_in = 1'b0;
    step(2);
    rst = 1'b1;
    step(20);
    check("t6_no_partial_push", 32'(bc_valid), 32'd0);
    check("t6_no_overflow", 32'(rx_overflow), 32'd0);
    check("t6_tx_idle", 32'(cmd_ready), 32'd1);
    rx_bits(16'h00FF, 15, 0, 1'b1);
    check("t6_new_valid", 32'(bc_valid), 32'd1);
    check("t6_new_data", 32'(bc_data), 32'h00FF);
    drain();

    // 7: random words with a consumer that is always ready
    do_reset();
    bc_ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          rx_bits(16'($urandom_range(0, 65535)), 15, 0, 1'b1);
          step($urandom_range(0, 3));
        end
      end
      begin
        for (int f = 0; f < 3; f++) tx_run(16'($urandom_range(0, 65535)));
      end
    join
    step(2);
    check("t7_overflow", 32'(rx_overflow), 32'd0);
    drain();
    check("t7_tx_q_empty", 32'(tx_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
